// File: rtl/cfa_window5x5_if.sv
// Pixel-stream in / 5x5 window out bundle for the CFA window stage.
interface cfa_window5x5_if #(
  parameter int W = 12
);
  logic            start;
  logic [W-1:0]    pix_in;
  logic            pix_valid;
  logic [25*W-1:0] win_out;
  logic            win_valid;
  logic [9:0]      center_row;
  logic [9:0]      center_col;
  logic            busy;
  logic            frame_done;

  modport master (
    output start, pix_in, pix_valid,
    input  win_out, win_valid, center_row, center_col, busy, frame_done
  );

  modport slave (
    input  start, pix_in, pix_valid,
    output win_out, win_valid, center_row, center_col, busy, frame_done
  );
endinterface

// File: rtl/cfa_window5x5.sv
// Buffers four CFA lines and emits every fully-interior 5x5 window, registered, with a strobe.
// state | meaning:  IDLE wait for start | FILL rows 0..3 loading | RUN windows possible | DONE one-cycle frame_done
module cfa_window5x5 #(
  parameter int pixelBitWidth = 12,
  parameter int IMG_WIDTH     = 64,
  parameter int IMG_HEIGHT    = 64
) (
  input logic            clk,
  input logic            rst,
  cfa_window5x5_if.slave bus
);
  localparam int W  = pixelBitWidth;
  localparam int CW = $clog2(IMG_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [9:0]       row_q, row_d, col_q, col_d;
  logic [W-1:0]     lb_mem [0:3][0:IMG_WIDTH-1];
  logic [W-1:0]     lb_rd  [0:3];
  logic [W-1:0]     sr_q   [0:4][0:4];
  logic [W-1:0]     sr_d   [0:4][0:4];
  logic [25*W-1:0]  win_q, win_d;
  logic             win_valid_q;
  logic [9:0]       center_row_q, center_col_q;
  logic [CW-1:0]    col_idx;
  logic             accept, strobe, last_col, last_row;
  logic             busy, frame_done;

  assign col_idx  = col_q[CW-1:0];
  assign accept   = bus.pix_valid && ((state_q == S_FILL) || (state_q == S_RUN));
  assign last_col = (col_q == 10'(IMG_WIDTH - 1));
  assign last_row = (row_q == 10'(IMG_HEIGHT - 1));
  // Column >= 4 keeps windows from straddling a line wrap.
  assign strobe   = accept && (row_q >= 10'd4) && (col_q >= 10'd4);

  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_FILL;
      S_FILL: begin
        busy = 1'b1;
        if (accept && (row_q == 10'd4) && (col_q == 10'd0)) state_d = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (accept && last_row && last_col) state_d = S_DONE;
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (accept) begin
      if (last_col) begin
        col_d = 10'd0;
        row_d = last_row ? 10'd0 : row_q + 10'd1;
      end else begin
        col_d = col_q + 10'd1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) lb_rd[k] = lb_mem[k][col_idx];
    sr_d = sr_q;
    if (accept) begin
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 4; c++) sr_d[r][c] = sr_q[r][c+1];
      sr_d[0][4] = lb_rd[3];
      sr_d[1][4] = lb_rd[2];
      sr_d[2][4] = lb_rd[1];
      sr_d[3][4] = lb_rd[0];
      sr_d[4][4] = bus.pix_in;
    end
    win_d = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) win_d[(r*5+c)*W +: W] = sr_d[r][c];
  end

  // Line buffers are plain RAM: no reset, written only on accept.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      lb_mem[0][col_idx] <= bus.pix_in;
      for (int k = 1; k < 4; k++) lb_mem[k][col_idx] <= lb_rd[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      center_row_q <= '0;
      center_col_q <= '0;
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++) sr_q[r][c] <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      sr_q        <= sr_d;
      win_valid_q <= strobe;
      if (strobe) begin
        win_q        <= win_d;
        center_row_q <= row_q - 10'd2;
        center_col_q <= col_q - 10'd2;
      end
    end
  end

  assign bus.win_out    = win_q;
  assign bus.win_valid  = win_valid_q;
  assign bus.center_row = center_row_q;
  assign bus.center_col = center_col_q;
  assign bus.busy       = busy;
  assign bus.frame_done = frame_done;
endmodule
